// File: rtl/rst_seq.sv
// rst_seq
//   Reset sequencer for the per-subsystem active-low resets of one clock
//   domain. After the domain reset releases, every output is held low for
//   HOLD_CYCLES edges, then the outputs release one at a time in index order
//   with GAP_CYCLES edges between releases. A four-phase software request
//   (sw_rst_req / sw_rst_ack) re-runs the whole assert/hold/release sequence.
//
// Ports
//   clk         in   clock, rising edge
//   rstn        in   async active-low reset (release already synchronized)
//   sw_rst_req  in   software reset request, level
//   sw_rst_ack  out  software reset acknowledge, level
//   rstn_out    out  [NUM_OUT] sequenced active-low resets, bit 0 first
//   busy        out  high while a sequence is in progress
//   done        out  high while every output is released
//
// state | meaning
// ------+---------------------------------------------------------------
// HOLD  | all outputs asserted, counting the minimum hold width
// GAP   | some outputs released, counting the gap before releasing idx
// RUN   | all outputs released, software handshake active
module rst_seq #(
  parameter int NUM_OUT     = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int GAP_CYCLES  = 8
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               sw_rst_req,
  output logic               sw_rst_ack,
  output logic [NUM_OUT-1:0] rstn_out,
  output logic               busy,
  output logic               done
);

  localparam int MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam int IDX_W   = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_OUT - 1);

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    GAP  = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  // Set when a request is accepted; resolved on the first RUN edge to decide
  // whether the requester is still waiting for an acknowledge.
  logic             pending;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= HOLD;
      cnt        <= '0;
      idx        <= '0;
      pending    <= 1'b0;
      rstn_out   <= '0;
      busy       <= 1'b1;
      done       <= 1'b0;
      sw_rst_ack <= 1'b0;
    end else begin
      case (state)
        HOLD: begin
          if (cnt == HOLD_LAST) begin
            cnt      <= '0;
            rstn_out <= NUM_OUT'(1);
            if (NUM_OUT == 1) begin
              state <= RUN;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              idx   <= IDX_W'(1);
              state <= GAP;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        GAP: begin
          if (cnt == GAP_LAST) begin
            cnt      <= '0;
            rstn_out <= rstn_out | (NUM_OUT'(1) << idx);
            if (idx == IDX_LAST) begin
              state <= RUN;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        RUN: begin
          if (pending) begin
            // Acknowledge only if the requester is still holding req.
            sw_rst_ack <= sw_rst_req;
            pending    <= 1'b0;
          end else if (sw_rst_ack) begin
            if (!sw_rst_req) sw_rst_ack <= 1'b0;
          end else if (sw_rst_req) begin
            rstn_out <= '0;
            done     <= 1'b0;
            busy     <= 1'b1;
            pending  <= 1'b1;
            cnt      <= '0;
            idx      <= '0;
            state    <= HOLD;
          end
        end

        default: begin
          state <= HOLD;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/rst_seq.md
# rst_seq

Reset sequencer that drives the per-subsystem active-low resets of one clock domain. After the domain reset is released, it holds every reset output asserted for a minimum width, then releases the outputs one at a time in index order with a fixed gap between releases. It also accepts a four-phase software reset request that re-runs the full assert/hold/release sequence. Each output is a registered, glitch-free level intended to drive the async-reset/sync-release cells of downstream blocks.

## Interface
- NUM_OUT, 4, number of sequenced reset outputs (≥1)
- HOLD_CYCLES, 16, clk edges all outputs stay asserted before rstn_out[0] releases (≥1)
- GAP_CYCLES, 8, clk edges between release of rstn_out[k-1] and rstn_out[k] (≥1)
- clk  input  1  single clock; all logic on rising edge
- rstn  input  1  asynchronous, active-low reset; assertion is asynchronous, release is taken synchronously by clk (already synchronized upstream)
- sw_rst_req  input  1  software reset request, level, synchronous to clk
- sw_rst_ack  output  1  software reset acknowledge, level
- rstn_out  output  NUM_OUT  sequenced active-low resets; bit 0 released first
- busy  output  1  high while a sequence is in progress
- done  output  1  high while all outputs are released (RUN)

## Operation
- Reset values (rstn low, asynchronous): rstn_out = all 0, busy = 1, done = 0, sw_rst_ack = 0, state = HOLD, counter = 0, idx = 0, pending = 0.
- State HOLD: all rstn_out low. The counter counts rising edges. On the HOLD_CYCLES-th edge, set rstn_out[0] = 1, idx = 1, and go to GAP. If NUM_OUT = 1, go to RUN instead.
- State GAP: the counter counts rising edges. On the GAP_CYCLES-th edge, set rstn_out[idx] = 1. If idx = NUM_OUT-1, go to RUN; otherwise increment idx and stay in GAP with the counter cleared.
- RUN entry edge: done = 1 and busy = 0, registered together with the final release.
- State RUN, software request:
  - If sw_rst_req = 1, sw_rst_ack = 0 and pending = 0 at an edge, then at that edge: all rstn_out = 0, done = 0, busy = 1, pending = 1, counter = 0, go to HOLD.
- State RUN, acknowledge:
  - If pending = 1 and sw_rst_req = 1 at an edge, set sw_rst_ack = 1 and clear pending.
  - If pending = 1 and sw_rst_req = 0, clear pending and do not raise ack.
- Ack release: while sw_rst_ack = 1, the first edge that samples sw_rst_req = 0 clears sw_rst_ack. No new request is accepted while ack is high.
- sw_rst_req is ignored in HOLD and GAP. Dropping req mid-sequence does not abort the sequence; it completes and ack is never raised.
- sw_rst_req held high through power-on reset is a new request: one edge after done first rises, a second sequence starts.
- Released outputs never re-assert except via rstn or an accepted software request; when that happens, all bits fall on the same edge.
- Counter width is clog2(max(HOLD_CYCLES, GAP_CYCLES)+1). idx width is clog2(NUM_OUT) (minimum 1). No wrap occurs, because the counter is cleared on every transition.

## Timing
- Edge numbering: edge 1 is the first rising clk edge that samples rstn high.
- Power-on release schedule:
  - rstn_out[0] rises at edge HOLD_CYCLES.
  - rstn_out[k] rises at edge HOLD_CYCLES + k·GAP_CYCLES.
  - done rises, and busy falls, at edge HOLD_CYCLES + (NUM_OUT-1)·GAP_CYCLES (call this D).
- Software request accepted at edge E:
  - all outputs fall at E.
  - rstn_out[0] rises at E+HOLD_CYCLES.
  - done rises at D' = E+HOLD_CYCLES+(NUM_OUT-1)·GAP_CYCLES.
  - sw_rst_ack rises at D'+1 if req is still high.
- Ack falls one edge after req is sampled low.
- rstn assertion at any point, including mid-HOLD, mid-GAP or while ack is high: all outputs drop immediately with no clock needed, and the full sequence restarts from edge 1.
- All outputs are flop outputs with no combinational paths from inputs.

## Test plan
All scenarios use NUM_OUT=3, HOLD_CYCLES=4, GAP_CYCLES=2 unless stated.
- Power-on: release rstn before edge 1 -> rstn_out = 000 through edge 3, 001 at edge 4, 011 at 6, 111 at 8; done = 1 and busy = 0 at 8.
- SW reset handshake: in RUN, raise req before edge 20 -> rstn_out = 000 and busy = 1 at 20; 001 at 24, 011 at 26, 111 and done at 28; ack = 1 at 29; drop req before edge 32 -> ack = 0 at 32, outputs stay 111.
- Req dropped mid-sequence: raise req before edge 20, drop before edge 22 -> sequence completes with 111 at 28; ack stays 0 throughout; next req is accepted normally.
- Async reset mid-GAP: pull rstn low between edges 25 and 26 of the handshake case -> rstn_out = 000, ack = 0 and done = 0 immediately, with no edge needed; after release, the schedule repeats with 001 at the new edge 4.
- Req held through power-on: req high from time 0 -> 111 at edge 8, new sequence accepted at edge 9 (outputs 000), 111 at 17, ack = 1 at 18.
- NUM_OUT=1, HOLD_CYCLES=1: release rstn -> rstn_out = 1 and done = 1 at edge 1.
